// File: rtl/uniq_pkg.sv
// Shared definitions for the uniq table reader.
// Provides the default word width, the slot count, the slot-index and count
// widths, and the emitter state encoding.
package uniq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int NSLOTS    = 4;
    localparam int IDX_W     = 2;
    localparam int COUNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/uniq_prio_pick.sv
// First-set-bit picker over the pending-slot mask.
// Ports:
//   mask - pending slots, bit 0 = slot 1
//   idx  - index of the lowest set bit (0 when mask is empty)
//   any  - at least one bit of mask is set
module uniq_prio_pick
    import uniq_pkg::*;
(
    input  logic [NSLOTS-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Lowest-index pending slot wins so words leave in slot order
    always_comb begin
        idx = 2'd0;
        any = 1'b0;
        casez (mask)
            4'b???1: begin idx = 2'd0; any = 1'b1; end
            4'b??10: begin idx = 2'd1; any = 1'b1; end
            4'b?100: begin idx = 2'd2; any = 1'b1; end
            4'b1000: begin idx = 2'd3; any = 1'b1; end
            default: begin idx = 2'd0; any = 1'b0; end
        endcase
    end

endmodule

// File: rtl/uniq_emit.sv
// Serial reader for the 4-slot uniq table.
// On start (in IDLE) the slot values and valid flags are snapshotted; the
// valid slots are then replayed in ascending slot order as a data_en stream
// with out_ready backpressure, followed by a one-cycle done pulse.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - snapshot request, honoured only in IDLE
//   in_1..in_4        - slot values
//   v_1..v_4          - slot valid flags
//   out_ready         - consumer accepts data_out on an edge with data_en
//   data_out, data_en - output word and its valid strobe (data_out is 0 when idle)
//   busy              - emission in progress
//   done              - one-cycle completion pulse
//   count             - words emitted in the last run
module uniq_emit
    import uniq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in_1,
    input  logic signed [WIDTH-1:0] in_2,
    input  logic signed [WIDTH-1:0] in_3,
    input  logic signed [WIDTH-1:0] in_4,
    input  logic                    v_1,
    input  logic                    v_2,
    input  logic                    v_3,
    input  logic                    v_4,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    data_en,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_W-1:0]      count
);

    state_t                  state_r, state_s;
    logic [NSLOTS-1:0]       mask_r, mask_s;
    logic signed [WIDTH-1:0] snap_r [NSLOTS];
    logic signed [WIDTH-1:0] snap_s [NSLOTS];
    logic [IDX_W-1:0]        cur_idx_r, cur_idx_s;
    logic signed [WIDTH-1:0] data_out_r, data_out_s;
    logic                    data_en_r, data_en_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic [COUNT_W-1:0]      count_r, count_s;

    logic signed [WIDTH-1:0] in_vec_s [NSLOTS];
    logic [NSLOTS-1:0]       v_vec_s;
    logic [NSLOTS-1:0]       clr_mask_s;
    logic [NSLOTS-1:0]       pick_mask_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_any_s;

    // Gather the table ports into indexable form
    always_comb begin
        in_vec_s[0] = in_1;
        in_vec_s[1] = in_2;
        in_vec_s[2] = in_3;
        in_vec_s[3] = in_4;
        v_vec_s     = {v_4, v_3, v_2, v_1};
    end

    // The picker looks ahead: fresh flags when starting, otherwise the mask
    // with the word now on data_out already removed, so the next word can be
    // registered on the same edge that accepts the current one (no bubble).
    always_comb begin
        clr_mask_s             = mask_r;
        clr_mask_s[cur_idx_r]  = 1'b0;
        pick_mask_s            = {NSLOTS{1'b0}};
        if (state_r == IDLE) begin
            pick_mask_s = v_vec_s;
        end else begin
            pick_mask_s = clr_mask_s;
        end
    end

    uniq_prio_pick u_pick (
        .mask (pick_mask_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_s    = state_r;
        mask_s     = mask_r;
        snap_s     = snap_r;
        cur_idx_s  = cur_idx_r;
        data_out_s = data_out_r;
        data_en_s  = data_en_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        count_s    = count_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    snap_s  = in_vec_s;
                    mask_s  = pick_mask_s;
                    count_s = {COUNT_W{1'b0}};
                    if (pick_any_s) begin
                        state_s    = SEND;
                        cur_idx_s  = pick_idx_s;
                        data_out_s = in_vec_s[pick_idx_s];
                        data_en_s  = 1'b1;
                        busy_s     = 1'b1;
                    end else begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    mask_s  = pick_mask_s;
                    count_s = count_r + COUNT_W'(1);
                    if (pick_any_s) begin
                        cur_idx_s  = pick_idx_s;
                        data_out_s = snap_r[pick_idx_s];
                    end else begin
                        state_s    = DONE;
                        data_out_s = {WIDTH{1'b0}};
                        data_en_s  = 1'b0;
                        busy_s     = 1'b0;
                        done_s     = 1'b1;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                mask_s     = {NSLOTS{1'b0}};
                data_out_s = {WIDTH{1'b0}};
                data_en_s  = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mask_r     <= {NSLOTS{1'b0}};
            snap_r     <= '{default: {WIDTH{1'b0}}};
            cur_idx_r  <= {IDX_W{1'b0}};
            data_out_r <= {WIDTH{1'b0}};
            data_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= {COUNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            mask_r     <= mask_s;
            snap_r     <= snap_s;
            cur_idx_r  <= cur_idx_s;
            data_out_r <= data_out_s;
            data_en_r  <= data_en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            count_r    <= count_s;
        end
    end

    assign data_out = data_out_r;
    assign data_en  = data_en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign count    = count_r;

endmodule

// File: tb/tb_uniq_emit.sv
// Self-checking bench for uniq_emit. Expected words go into a queue when a
// run is started and are popped as the DUT hands them over.
module tb_uniq_emit;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [7:0] in_1, in_2, in_3, in_4;
    logic              v_1, v_2, v_3, v_4;
    logic              out_ready;
    logic signed [7:0] data_out;
    logic              data_en;
    logic              busy;
    logic              done;
    logic [2:0]        count;

    int checks   = 0;
    int failures = 0;
    logic signed [7:0] exp_q [$];

    uniq_emit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_4      (in_4),
        .v_1       (v_1),
        .v_2       (v_2),
        .v_3       (v_3),
        .v_4       (v_4),
        .out_ready (out_ready),
        .data_out  (data_out),
        .data_en   (data_en),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic load(input logic signed [7:0] a, b, c, d, input logic [3:0] v);
        in_1 = a; in_2 = b; in_3 = c; in_4 = d;
        {v_4, v_3, v_2, v_1} = v;
        exp_q.delete();
        if (v[0]) exp_q.push_back(a);
        if (v[1]) exp_q.push_back(b);
        if (v[2]) exp_q.push_back(c);
        if (v[3]) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        load(8'sd0, 8'sd0, 8'sd0, 8'sd0, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (data_out !== 8'sd0) begin failures++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
        checks++; if (data_en !== 1'b0) begin failures++; $display("FAIL reset_data_en got=%b exp=0", data_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        bit got_done = 1'b0;
        load(8'sd1, 8'sd2, 8'sd3, 8'sd4, 4'b1111);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            @(negedge clk);
            checks++; if (data_en !== (c < 4)) begin failures++; $display("FAIL stream_en cyc=%0d got=%b exp=%b", c, data_en, (c < 4)); end
            if (data_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra got=%0d exp=none", data_out); end
                else if (data_out !== exp_q[0]) begin failures++; $display("FAIL stream_word got=%0d exp=%0d", data_out, exp_q[0]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (c == 0) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stream_busy got=%b exp=1", busy); end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++; if (c != 4) begin failures++; $display("FAIL stream_done_cyc got=%0d exp=4", c); end
                checks++; if (count !== 3'd4) begin failures++; $display("FAIL stream_count got=%0d exp=4", count); end
                checks++; if (data_out !== 8'sd0) begin failures++; $display("FAIL stream_idle_out got=%0d exp=0", data_out); end
            end
            @(posedge clk); #1;
        end
        checks++; if (!got_done || exp_q.size() != 0) begin failures++; $display("FAIL stream_complete got_done=%b left=%0d exp_done=1 left=0", got_done, exp_q.size()); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL stream_after got done=%b count=%0d exp done=0 count=4", done, count); end
        @(posedge clk); #1;
    endtask

    task automatic test_skip();
        bit got_done = 1'b0;
        load(8'sd5, 8'sd9, -8'sd7, 8'sd3, 4'b0101);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 8 && !got_done; c++) begin
            @(negedge clk);
            checks++; if (data_en !== (c < 2)) begin failures++; $display("FAIL skip_en cyc=%0d got=%b exp=%b", c, data_en, (c < 2)); end
            if (data_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL skip_extra got=%0d exp=none", data_out); end
                else if (data_out !== exp_q[0]) begin failures++; $display("FAIL skip_word got=%0d exp=%0d", data_out, exp_q[0]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++; if (c != 2) begin failures++; $display("FAIL skip_done_cyc got=%0d exp=2", c); end
                checks++; if (count !== 3'd2) begin failures++; $display("FAIL skip_count got=%0d exp=2", count); end
            end
            @(posedge clk); #1;
        end
        checks++; if (!got_done || exp_q.size() != 0) begin failures++; $display("FAIL skip_complete got_done=%b left=%0d exp_done=1 left=0", got_done, exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        load(8'sd11, 8'sd12, 8'sd13, 8'sd14, 4'b0000);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++; if (data_en !== 1'b0) begin failures++; $display("FAIL empty_en got=%b exp=0", data_en); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", done); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || data_en !== 1'b0) begin failures++; $display("FAIL empty_after got done=%b en=%b exp done=0 en=0", done, data_en); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit got_done = 1'b0;
        int hold2 = 0;
        load(8'sd1, 8'sd2, 8'sd3, 8'sd4, 4'b1111);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 14 && !got_done; c++) begin
            @(negedge clk);
            checks++; if (data_en !== (c < 7)) begin failures++; $display("FAIL bp_en cyc=%0d got=%b exp=%b", c, data_en, (c < 7)); end
            if (data_en === 1'b1) begin
                if (data_out === 8'sd2) hold2++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%0d exp=none", data_out); end
                else if (data_out !== exp_q[0]) begin failures++; $display("FAIL bp_word cyc=%0d got=%0d exp=%0d", c, data_out, exp_q[0]); end
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++; if (c != 7) begin failures++; $display("FAIL bp_done_cyc got=%0d exp=7", c); end
                checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", count); end
            end
            @(posedge clk);
            #1 out_ready = !((c + 1) >= 1 && (c + 1) <= 3);
        end
        out_ready = 1'b1;
        checks++; if (hold2 != 4) begin failures++; $display("FAIL bp_hold got=%0d exp=4", hold2); end
        checks++; if (!got_done || exp_q.size() != 0) begin failures++; $display("FAIL bp_complete got_done=%b left=%0d exp_done=1 left=0", got_done, exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore();
        int n_done = 0;
        load(8'sd1, 8'sd2, 8'sd3, 8'sd4, 4'b1111);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++; if (data_en !== (c < 4)) begin failures++; $display("FAIL ign_en cyc=%0d got=%b exp=%b", c, data_en, (c < 4)); end
            if (data_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL ign_extra got=%0d exp=none", data_out); end
                else if (data_out !== exp_q[0]) begin failures++; $display("FAIL ign_word got=%0d exp=%0d", data_out, exp_q[0]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (done === 1'b1) n_done++;
            @(posedge clk);
            #1;
            if (c == 1) begin start = 1'b1; in_1 = 8'sd99; end
            else start = 1'b0;
        end
        start = 1'b0; in_1 = 8'sd1;
        checks++; if (n_done != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ign_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midrun();
        bit got_done = 1'b0;
        load(8'sd1, 8'sd2, 8'sd3, 8'sd4, 4'b1111);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (data_en !== 1'b1 || data_out !== 8'sd3) begin failures++; $display("FAIL rmid_word3 got en=%b out=%0d exp en=1 out=3", data_en, data_out); end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (data_out !== 8'sd0 || data_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL rmid_zero cyc=%0d got out=%0d en=%b busy=%b done=%b count=%0d exp all 0", c, data_out, data_en, busy, done, count);
            end
            @(posedge clk); #1;
        end
        load(8'sd4, 8'sd3, 8'sd2, 8'sd1, 4'b1111);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            @(negedge clk);
            checks++; if (data_en !== (c < 4)) begin failures++; $display("FAIL rmid_en cyc=%0d got=%b exp=%b", c, data_en, (c < 4)); end
            if (data_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rmid_extra got=%0d exp=none", data_out); end
                else if (data_out !== exp_q[0]) begin failures++; $display("FAIL rmid_word got=%0d exp=%0d", data_out, exp_q[0]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++; if (count !== 3'd4) begin failures++; $display("FAIL rmid_count got=%0d exp=4", count); end
            end
            @(posedge clk); #1;
        end
        checks++; if (!got_done || exp_q.size() != 0) begin failures++; $display("FAIL rmid_complete got_done=%b left=%0d exp_done=1 left=0", got_done, exp_q.size()); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_stream();
        test_skip();
        test_empty();
        test_backpressure();
        test_ignore();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
